vga_bounce_renderer: RTL and testbench

- Pixel-generation stage that sits directly downstream of the hvsync_generator timing block.
- Consumes the beam position and display-area flag, and renders a solid box on a background colour.
- The box bounces off the active-area edges, advancing once per frame. Each wall hit changes the box colour and triggers a white flash.
- Produces the registered 3-bit RGB pixel that drives the VGA DAC pins.

---
 rtl/vga_bounce_renderer.sv | 172 +++++++++++++++++
 tb/tb_vga_bounce_renderer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_renderer.sv
// Pixel stage behind the VGA timing generator: draws a bouncing box over a
// background colour, recolouring and flashing white on every wall hit.
module vga_bounce_renderer #(
  parameter int         H_ACTIVE     = 640,
  parameter int         V_ACTIVE     = 480,
  parameter int         BOX_SIZE     = 32,
  parameter int         SPEED        = 2,
  parameter int         FLASH_FRAMES = 8,
  parameter logic [2:0] BG_COLOR     = 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        in_display_area,
  input  logic        run,
  output logic [2:0]  pixel,
  output logic        bounce,
  output logic        corner,
  output logic [15:0] hit_count
);

  localparam int          FW      = $clog2(FLASH_FRAMES + 1);
  localparam logic [10:0] LIM_X   = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] LIM_Y   = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] SPEED_W = 11'(SPEED);
  localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);
  localparam logic [9:0]  START_X = 10'((H_ACTIVE - BOX_SIZE) / 2);
  localparam logic [9:0]  START_Y = 10'((V_ACTIVE - BOX_SIZE) / 2);

  typedef enum logic [1:0] {IDLE, MOVE, FLASH} state_t;

  state_t          state_q, state_d;
  logic [9:0]      box_x_q, box_x_d, box_y_q, box_y_d;
  logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]      color_q, color_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic [2:0]      pixel_q, pixel_d;
  logic            bounce_q, bounce_d, corner_q, corner_d;
  logic [15:0]     hit_count_q, hit_count_d;

  logic            frame_tick, hit_x, hit_y, do_move, in_box;
  logic [11:0]     step_x, step_y;

  // Returns {hit, new_dir_is_negative, new_pos}; clamps at either wall.
  function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir_neg,
                                            input logic [10:0] limit);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!dir_neg) begin
      if (p + SPEED_W >= limit) return {1'b1, 1'b1, limit[9:0]};
      else                      return {1'b0, 1'b0, 10'(p + SPEED_W)};
    end else begin
      if (p <= SPEED_W) return {1'b1, 1'b0, 10'd0};
      else              return {1'b0, 1'b1, 10'(p - SPEED_W)};
    end
  endfunction

  // Black is reserved for blanking, so the colour cycle skips it.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    logic [2:0] n;
    n = c + 3'd1;
    return (n == 3'd0) ? 3'd1 : n;
  endfunction

  assign frame_tick = pix_ce && (counter_x == 10'd0) && ({1'b0, counter_y} == 11'(V_ACTIVE));
  assign step_x = step_axis(box_x_q, dir_x_q, LIM_X);
  assign step_y = step_axis(box_y_q, dir_y_q, LIM_Y);
  assign hit_x  = step_x[11];
  assign hit_y  = step_y[11];
  assign in_box = ({1'b0, counter_x} >= {1'b0, box_x_q}) &&
                  ({1'b0, counter_x} <  {1'b0, box_x_q} + BOX_W) &&
                  ({1'b0, counter_y} >= {1'b0, box_y_q}) &&
                  ({1'b0, counter_y} <  {1'b0, box_y_q} + BOX_W);

  always_comb begin
    state_d     = state_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    color_d     = color_q;
    flash_d     = flash_q;
    pixel_d     = pixel_q;
    bounce_d    = 1'b0;
    corner_d    = 1'b0;
    hit_count_d = hit_count_q;
    do_move     = 1'b0;

    if (frame_tick) begin
      case (state_q)
        IDLE:  if (run) state_d = MOVE;
        MOVE:  if (!run) state_d = IDLE;
               else do_move = 1'b1;
        FLASH: begin
          if (!run) begin
            state_d = IDLE;
            flash_d = '0;
          end else begin
            do_move = 1'b1;
            if (!(hit_x || hit_y)) begin
              if (flash_q <= FW'(1)) begin
                flash_d = '0;
                state_d = MOVE;
              end else begin
                flash_d = flash_q - FW'(1);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_move) begin
      box_x_d = step_x[9:0];
      dir_x_d = step_x[10];
      box_y_d = step_y[9:0];
      dir_y_d = step_y[10];
      if (hit_x || hit_y) begin
        state_d     = FLASH;
        bounce_d    = 1'b1;
        corner_d    = hit_x && hit_y;
        hit_count_d = hit_count_q + 16'd1;
        color_d     = next_color(color_q);
        flash_d     = FW'(FLASH_FRAMES);
      end
    end

    // Output stage: one pix_ce of latency from the beam counters.
    if (pix_ce) begin
      if (!in_display_area) pixel_d = 3'b000;
      else if (in_box)      pixel_d = (flash_q != '0) ? 3'b111 : color_q;
      else                  pixel_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      box_x_q     <= START_X;
      box_y_q     <= START_Y;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      color_q     <= 3'b100;
      flash_q     <= '0;
      pixel_q     <= 3'b000;
      bounce_q    <= 1'b0;
      corner_q    <= 1'b0;
      hit_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      color_q     <= color_d;
      flash_q     <= flash_d;
      pixel_q     <= pixel_d;
      bounce_q    <= bounce_d;
      corner_q    <= corner_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign pixel     = pixel_q;
  assign bounce    = bounce_q;
  assign corner    = corner_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Directed bench for vga_bounce_renderer: default instance plus a square
// (V_ACTIVE=640) instance for the simultaneous-corner case.
module tb_vga_bounce_renderer;
  logic        clk = 1'b0;
  logic        rst, pix_ce, disp, run;
  logic [9:0]  counter_x, counter_y;
  logic [2:0]  pixel_a, pixel_b;
  logic        bounce_a, corner_a, bounce_b, corner_b;
  logic [15:0] hit_count_a, hit_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       d;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  vga_bounce_renderer dut_a (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(disp), .run(run), .pixel(pixel_a), .bounce(bounce_a),
    .corner(corner_a), .hit_count(hit_count_a));

  vga_bounce_renderer #(.V_ACTIVE(640)) dut_b (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(disp), .run(run), .pixel(pixel_b), .bounce(bounce_b),
    .corner(corner_b), .hit_count(hit_count_b));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic d,
                       output logic [2:0] pa, output logic [2:0] pb);
    counter_x = x; counter_y = y; disp = d; pix_ce = 1'b1;
    @(posedge clk); #1;
    pa = pixel_a; pb = pixel_b;
    pix_ce = 1'b0;
  endtask

  task automatic tick(input logic [9:0] ty, output logic ba, output logic ca,
                      output logic bb, output logic cb);
    counter_x = 10'd0; counter_y = ty; disp = 1'b0; pix_ce = 1'b1;
    @(posedge clk); #1;
    ba = bounce_a; ca = corner_a; bb = bounce_b; cb = corner_b;
    pix_ce = 1'b0;
  endtask

  task automatic ticks_no_bounce(input int n, input string name);
    logic ba, ca, bb, cb;
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick(10'd480, ba, ca, bb, cb);
      if (ba || bb) bad++;
    end
    check(name, 16'(bad), 16'd0);
  endtask

  task automatic run_to_bounce(input logic [9:0] ty, input int limit,
                               output int n, output logic c);
    logic ba, ca, bb, cb;
    n = 0; c = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      tick(ty, ba, ca, bb, cb);
      if ((ty == 10'd640) ? bb : ba) begin
        n = i; c = (ty == 10'd640) ? cb : ca;
        break;
      end
    end
  endtask

  initial begin
    logic [2:0] pa, pb;
    logic       ba, ca, bb, cb, c;
    int         n;

    vecs[0] = '{10'd304, 10'd224, 1'b1, 3'b100};
    vecs[1] = '{10'd335, 10'd255, 1'b1, 3'b100};
    vecs[2] = '{10'd336, 10'd224, 1'b1, 3'b001};
    vecs[3] = '{10'd303, 10'd224, 1'b1, 3'b001};
    vecs[4] = '{10'd304, 10'd256, 1'b1, 3'b001};
    vecs[5] = '{10'd304, 10'd223, 1'b1, 3'b001};
    vecs[6] = '{10'd0,   10'd0,   1'b1, 3'b001};
    vecs[7] = '{10'd639, 10'd479, 1'b1, 3'b001};
    vecs[8] = '{10'd700, 10'd10,  1'b0, 3'b000};
    vecs[9] = '{10'd304, 10'd224, 1'b0, 3'b000};

    rst = 1'b1; pix_ce = 1'b0; disp = 1'b0; run = 1'b0;
    counter_x = 10'd0; counter_y = 10'd0;
    @(posedge clk); #1;
    check("reset pixel", 16'(pixel_a), 16'd0);
    check("reset bounce", 16'(bounce_a), 16'd0);
    check("reset corner", 16'(corner_a), 16'd0);
    check("reset hit_count", hit_count_a, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      probe(vecs[i].x, vecs[i].y, vecs[i].d, pa, pb);
      check($sformatf("vec%0d pixel", i), 16'(pa), 16'(vecs[i].exp));
    end

    // latency and hold: no pix_ce -> pixel unchanged, then follows counters
    probe(10'd0, 10'd0, 1'b1, pa, pb);
    counter_x = 10'd304; counter_y = 10'd224;
    @(posedge clk); #1;
    check("hold without pix_ce", 16'(pixel_a), 16'b001);
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    check("one ce latency", 16'(pixel_a), 16'b100);

    ticks_no_bounce(3, "idle no bounce");
    probe(10'd304, 10'd224, 1'b1, pa, pb); check("idle frozen in", 16'(pa), 16'b100);
    probe(10'd303, 10'd223, 1'b1, pa, pb); check("idle frozen out", 16'(pa), 16'b001);

    run = 1'b1;
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd304, 10'd224, 1'b1, pa, pb); check("start tick no move", 16'(pa), 16'b100);
    probe(10'd303, 10'd224, 1'b1, pa, pb); check("start tick edge", 16'(pa), 16'b001);
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd306, 10'd226, 1'b1, pa, pb); check("move1 corner px", 16'(pa), 16'b100);
    probe(10'd305, 10'd226, 1'b1, pa, pb); check("move1 left", 16'(pa), 16'b001);
    probe(10'd306, 10'd225, 1'b1, pa, pb); check("move1 top", 16'(pa), 16'b001);
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd308, 10'd228, 1'b1, pa, pb); check("move2 corner px", 16'(pa), 16'b100);
    probe(10'd307, 10'd228, 1'b1, pa, pb); check("move2 left", 16'(pa), 16'b001);

    ticks_no_bounce(109, "no early y bounce");
    tick(10'd480, ba, ca, bb, cb);
    check("y hit bounce", 16'(ba), 16'd1);
    check("y hit corner", 16'(ca), 16'd0);
    @(posedge clk); #1;
    check("bounce one clk", 16'(bounce_a), 16'd0);
    check("hit_count 1", hit_count_a, 16'd1);
    probe(10'd528, 10'd448, 1'b1, pa, pb); check("flash at clamp", 16'(pa), 16'b111);
    probe(10'd559, 10'd479, 1'b1, pa, pb); check("flash far corner", 16'(pa), 16'b111);
    probe(10'd528, 10'd447, 1'b1, pa, pb); check("above clamp", 16'(pa), 16'b001);
    ticks_no_bounce(7, "flash ticks");
    probe(10'd542, 10'd434, 1'b1, pa, pb); check("flash frame 8", 16'(pa), 16'b111);
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd544, 10'd432, 1'b1, pa, pb); check("after flash color", 16'(pa), 16'b101);

    ticks_no_bounce(31, "no early x bounce");
    tick(10'd480, ba, ca, bb, cb);
    check("x hit bounce", 16'(ba), 16'd1);
    check("x hit corner", 16'(ca), 16'd0);
    check("hit_count 2", hit_count_a, 16'd2);
    tick(10'd480, ba, ca, bb, cb);
    run = 1'b0;
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd606, 10'd366, 1'b1, pa, pb); check("drop run flash clr", 16'(pa), 16'b110);
    ticks_no_bounce(2, "idle after drop");
    probe(10'd606, 10'd366, 1'b1, pa, pb); check("drop run frozen", 16'(pa), 16'b110);
    probe(10'd605, 10'd366, 1'b1, pa, pb); check("drop run frozen edge", 16'(pa), 16'b001);
    run = 1'b1;
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd606, 10'd366, 1'b1, pa, pb); check("resume no move", 16'(pa), 16'b110);
    probe(10'd605, 10'd366, 1'b1, pa, pb); check("resume no move edge", 16'(pa), 16'b001);
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd604, 10'd364, 1'b1, pa, pb); check("resume moved", 16'(pa), 16'b110);
    probe(10'd604, 10'd363, 1'b1, pa, pb); check("resume moved edge", 16'(pa), 16'b001);

    run_to_bounce(10'd480, 400, n, c);
    check("ticks to top wall", 16'(n), 16'd182);
    run = 1'b0;
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd240, 10'd0, 1'b1, pa, pb); check("color 7", 16'(pa), 16'b111);
    check("hit_count 3", hit_count_a, 16'd3);
    run = 1'b1;
    tick(10'd480, ba, ca, bb, cb);
    run_to_bounce(10'd480, 400, n, c);
    check("ticks to left wall", 16'(n), 16'd120);
    run = 1'b0;
    tick(10'd480, ba, ca, bb, cb);
    probe(10'd0, 10'd240, 1'b1, pa, pb); check("color wrap 7->1", 16'(pa), 16'b001);
    check("hit_count 4", hit_count_a, 16'd4);

    // reset mid-line without pix_ce
    counter_x = 10'd100; counter_y = 10'd100; disp = 1'b1; pix_ce = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midline rst pixel", 16'(pixel_a), 16'd0);
    check("midline rst hit_count", hit_count_a, 16'd0);
    probe(10'd304, 10'd224, 1'b1, pa, pb); check("rst position", 16'(pa), 16'b100);
    probe(10'd303, 10'd224, 1'b1, pa, pb); check("rst position edge", 16'(pa), 16'b001);

    run = 1'b1;
    tick(10'd640, ba, ca, bb, cb);
    run_to_bounce(10'd640, 200, n, c);
    check("square ticks to corner", 16'(n), 16'd152);
    check("square corner flag", 16'(c), 16'd1);
    check("square hit_count", hit_count_b, 16'd1);
    @(posedge clk); #1;
    check("corner one clk", 16'(corner_b), 16'd0);
    run = 1'b0;
    tick(10'd640, ba, ca, bb, cb);
    probe(10'd608, 10'd608, 1'b1, pa, pb); check("square color once", 16'(pb), 16'b101);
    check("square hit_count held", hit_count_b, 16'd1);
    check("default untouched", hit_count_a, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
